// File: rtl/mips_instr_encoder_if.sv
// Request channel into the MIPS instruction encoder: a symbolic instruction
// (kind plus register/immediate fields) with a valid/ready handshake.
interface mips_instr_encoder_if;
    logic        valid;
    logic        ready;
    logic [3:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;

    modport master (output valid, kind, rs, rt, rd, imm, target, input ready);
    modport slave  (input valid, kind, rs, rt, rd, imm, target, output ready);
endinterface

// File: rtl/mips_instr_encoder.sv
// Packs symbolic MIPS requests into 32-bit words and writes them sequentially into imem.
// Optional feature macro MIPS_ENC_NOP_PAD_EN: write a nop slot after every BEQ/J.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting requests, one word per cycle
// PAD   | writing the nop slot after a BEQ/J (MIPS_ENC_NOP_PAD_EN only)
// FULL  | all DEPTH words written, no writes until start
module mips_instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    mips_instr_encoder_if.slave req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_wa,
    output logic [31:0]       imem_wd,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    localparam logic [3:0] K_ADD  = 4'd0;
    localparam logic [3:0] K_SUB  = 4'd1;
    localparam logic [3:0] K_AND  = 4'd2;
    localparam logic [3:0] K_OR   = 4'd3;
    localparam logic [3:0] K_SLT  = 4'd4;
    localparam logic [3:0] K_LW   = 4'd5;
    localparam logic [3:0] K_SW   = 4'd6;
    localparam logic [3:0] K_BEQ  = 4'd7;
    localparam logic [3:0] K_ADDI = 4'd8;
    localparam logic [3:0] K_J    = 4'd9;

`ifdef MIPS_ENC_NOP_PAD_EN
    typedef enum logic [1:0] {IDLE, RUN, PAD, FULL} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;
`endif

    state_t            state, state_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] wa_nxt;
    logic [31:0]       wd_nxt;
    logic [ADDR_W:0]   count_nxt;
    logic [ADDR_W:0]   count_inc;
    logic              err_nxt;
    logic              hs;
    logic              legal;
    logic [31:0]       word;

    assign full      = (count == DEPTH);
    assign req.ready = (state == RUN) & ~start & ~full;
    assign hs        = req.valid & req.ready;
    assign count_inc = count + ONE;

`ifdef MIPS_ENC_NOP_PAD_EN
    logic is_ctl;
    assign is_ctl = (req.kind == K_BEQ) | (req.kind == K_J);
`endif

    // Opcode/funct values mirror the single-cycle control decoder.
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (req.kind)
            K_ADD:   word = {6'b000000, req.rs, req.rt, req.rd, 5'b00000, 6'b100000};
            K_SUB:   word = {6'b000000, req.rs, req.rt, req.rd, 5'b00000, 6'b100010};
            K_AND:   word = {6'b000000, req.rs, req.rt, req.rd, 5'b00000, 6'b100100};
            K_OR:    word = {6'b000000, req.rs, req.rt, req.rd, 5'b00000, 6'b100101};
            K_SLT:   word = {6'b000000, req.rs, req.rt, req.rd, 5'b00000, 6'b101010};
            K_LW:    word = {6'b100011, req.rs, req.rt, req.imm};
            K_SW:    word = {6'b101011, req.rs, req.rt, req.imm};
            K_BEQ:   word = {6'b000100, req.rs, req.rt, req.imm};
            K_ADDI:  word = {6'b001000, req.rs, req.rt, req.imm};
            K_J:     word = {6'b000010, req.target};
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        we_nxt    = 1'b0;
        wa_nxt    = imem_wa;
        wd_nxt    = imem_wd;
        count_nxt = count;
        err_nxt   = err;
        if (start) begin
            // Restart wins over everything, including a pending pad slot.
            state_nxt = RUN;
            count_nxt = '0;
            err_nxt   = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (hs) begin
                        if (!legal) begin
                            err_nxt = 1'b1;
                        end else begin
                            we_nxt    = 1'b1;
                            wa_nxt    = count[ADDR_W-1:0];
                            wd_nxt    = word;
                            count_nxt = count_inc;
                            if (count_inc == DEPTH)
                                state_nxt = FULL;
`ifdef MIPS_ENC_NOP_PAD_EN
                            else if (is_ctl)
                                state_nxt = PAD;
`endif
                        end
                    end
                end
`ifdef MIPS_ENC_NOP_PAD_EN
                PAD: begin
                    we_nxt    = 1'b1;
                    wa_nxt    = count[ADDR_W-1:0];
                    wd_nxt    = 32'h0000_0000;
                    count_nxt = count_inc;
                    state_nxt = (count_inc == DEPTH) ? FULL : RUN;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            imem_we <= 1'b0;
            imem_wa <= '0;
            imem_wd <= '0;
            count   <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            imem_we <= we_nxt;
            imem_wa <= wa_nxt;
            imem_wd <= wd_nxt;
            count   <= count_nxt;
            err     <= err_nxt;
        end
    end

endmodule
